stutter_scheduler: RTL and testbench
====================================

Name: stutter_scheduler

Overview:
- Drives the stutter_in inputs of two codeblock instances, a source program A and its compiled target B, so that their observable outputs change in lock-step.
- The block is the producer side of the stutter interface that codeblocks consume. It sits in the asynchronous-hyperltl compiler-optimisation harness, between the two codeblocks and the property checker.
- When one side's observable changes, that side is stuttered until the other side's observable also changes, or until a fairness bound expires.
- Alignment mismatches and fairness violations are flagged for the checker.

Parameters:
- W, 1, width of each observable (codeblock output x).
- MAX_STUTTER, 7, maximum consecutive stutter cycles for one side before a forced release; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_STUTTER.

Ports:
- clk  in  1  rising-edge clock, shared with both codeblocks.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scheduler active; when low, both sides are frozen.
- obs_a  in  W  observable of side A (registered output of codeblock A).
- obs_b  in  W  observable of side B.
- stutter_a  out  1  to codeblock A stutter_in; combinational (Mealy).
- stutter_b  out  1  to codeblock B stutter_in; combinational (Mealy).
- aligned  out  1  registered one-cycle pulse; both sides accepted a change together.
- mismatch  out  1  sticky; set when an aligned pair of accepted values differs.
- fair_violation  out  1  sticky; set on a forced release after MAX_STUTTER.

Behaviour:
- Internal state:
  - FSM state: RUN, HOLD_A, HOLD_B.
  - last_a, last_b: last accepted values, W bits each.
  - hold_cnt: CNT_W bits.
- Reset (rst_n low, asynchronous):
  - state=RUN; last_a=last_b=0, matching codeblock initial x=0; hold_cnt=0.
  - aligned=0, mismatch=0, fair_violation=0.
  - While rst_n is low, stutter_a=stutter_b=1.
  - Reset mid-hold discards the hold with no flag.
- Change detect: chg_a = (obs_a != last_a); chg_b = (obs_b != last_b).
- enable low (overrides every state):
  - stutter_a=stutter_b=1.
  - No register updates; aligned=0.
- RUN:
  - No change on either side: stutter_a=stutter_b=0; stay in RUN.
  - chg_a & chg_b: both accepted (last_a<=obs_a, last_b<=obs_b); stutter outputs 0.
    - aligned pulses next cycle.
    - mismatch<=1 if obs_a != obs_b.
  - chg_a & !chg_b: stutter_a=1 in the same cycle, so A does not advance at this edge.
    - last_a<=obs_a, hold_cnt<=1, state<=HOLD_A.
  - chg_b & !chg_a: symmetric; enters HOLD_B.
- HOLD_A:
  - chg_b: stutter_a=0, stutter_b=0; last_b<=obs_b; state<=RUN.
    - aligned pulses next cycle.
    - mismatch<=1 if obs_b != last_a.
  - !chg_b and hold_cnt < MAX_STUTTER: stutter_a=1; hold_cnt<=hold_cnt+1.
  - !chg_b and hold_cnt == MAX_STUTTER: stutter_a=0 (forced release); fair_violation<=1; state<=RUN.
  - Result: side A is frozen for at most MAX_STUTTER consecutive cycles.
  - A change on obs_a while in HOLD_A is ignored, because A is frozen and cannot legally change.
  - stutter_b=0 throughout HOLD_A.
- HOLD_B: mirror of HOLD_A with A and B swapped.
- Timing:
  - stutter outputs have zero latency from obs_*, state and enable.
  - aligned has one cycle of latency.
  - mismatch and fair_violation are sticky until reset.
- Width rules:
  - Comparisons are full-width unsigned.
  - hold_cnt never wraps, because it stops at MAX_STUTTER.

Optional Feature:
- Macro: STUTTER_TRACE_EN.
- Defined:
  - Adds outputs stutter_cnt_a and stutter_cnt_b, 8 bits each.
  - Each counts cycles in which the corresponding stutter output is 1 while rst_n is high and enable is high.
  - Counts saturate at 255 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then obs_a=obs_b=0 for 10 cycles -> stutter_a=stutter_b=1 during reset, 0 afterwards; aligned, mismatch, fair_violation all stay 0.
- Simultaneous change: obs_a and obs_b go 0->1 in the same cycle -> no stutter; aligned=1 exactly one cycle later; mismatch=0.
- A leads by 3 cycles: obs_a goes 0->1 at cycle 5, obs_b goes 0->1 at cycle 8 -> stutter_a=1 in cycles 5,6,7 and 0 at cycle 8; aligned pulses at cycle 9; stutter_b=0 throughout.
- Mismatch, W=2: obs_b goes 0->2 at cycle 4, obs_a goes 0->3 at cycle 6 -> stutter_b=1 in cycles 4,5; mismatch=1 from cycle 7 and stays 1.
- Fairness bound, MAX_STUTTER=7: obs_a toggles and obs_b never changes -> stutter_a=1 for exactly 7 cycles, then 0; fair_violation=1 from the next cycle; state returns to RUN.
- enable low during HOLD_A after 2 hold cycles, for 4 cycles -> both stutter outputs 1, hold_cnt frozen at 2; after enable rises, the release occurs 5 cycles later if obs_b stays constant.

Source files
------------

// File: rtl/stutter_scheduler.sv
`default_nettype none
// ============================================================================
// stutter_scheduler : lock-step stutter producer for a source/target codeblock
//   pair. Optional STUTTER_TRACE_EN adds per-side stutter counters. Rev 1.0
// ============================================================================
module stutter_scheduler #(
  parameter int W           = 1,
  parameter int MAX_STUTTER = 7,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [W-1:0] obs_a,
  input  logic [W-1:0] obs_b,
  output logic         stutter_a,
  output logic         stutter_b,
  output logic         aligned,
  output logic         mismatch,
  output logic         fair_violation
`ifdef STUTTER_TRACE_EN
  ,
  output logic [7:0]   stutter_cnt_a,
  output logic [7:0]   stutter_cnt_b
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STUTTER);

  state_t           state_q, state_d;
  logic [W-1:0]     last_a_q, last_a_d;
  logic [W-1:0]     last_b_q, last_b_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             aligned_q, aligned_d;
  logic             mismatch_q, mismatch_d;
  logic             fair_q, fair_d;
  logic             stall_a, stall_b;
  logic             chg_a, chg_b;

  assign chg_a = (obs_a != last_a_q);
  assign chg_b = (obs_b != last_b_q);

  always_comb begin
    state_d    = state_q;
    last_a_d   = last_a_q;
    last_b_d   = last_b_q;
    hold_cnt_d = hold_cnt_q;
    aligned_d  = 1'b0;
    mismatch_d = mismatch_q;
    fair_d     = fair_q;
    stall_a    = 1'b0;
    stall_b    = 1'b0;
    if (!enable) begin
      stall_a = 1'b1;
      stall_b = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (chg_a && chg_b) begin
            last_a_d  = obs_a;
            last_b_d  = obs_b;
            aligned_d = 1'b1;
            if (obs_a != obs_b) mismatch_d = 1'b1;
          end else if (chg_a) begin
            stall_a    = 1'b1;
            last_a_d   = obs_a;
            hold_cnt_d = CNT_W'(1);
            state_d    = HOLD_A;
          end else if (chg_b) begin
            stall_b    = 1'b1;
            last_b_d   = obs_b;
            hold_cnt_d = CNT_W'(1);
            state_d    = HOLD_B;
          end
        end
        HOLD_A: begin
          // obs_a is frozen here, so only B can complete the pair
          if (chg_b) begin
            last_b_d   = obs_b;
            aligned_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = RUN;
            if (obs_b != last_a_q) mismatch_d = 1'b1;
          end else if (hold_cnt_q < MAX_CNT) begin
            stall_a    = 1'b1;
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end else begin
            fair_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = RUN;
          end
        end
        HOLD_B: begin
          if (chg_a) begin
            last_a_d   = obs_a;
            aligned_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = RUN;
            if (obs_a != last_b_q) mismatch_d = 1'b1;
          end else if (hold_cnt_q < MAX_CNT) begin
            stall_b    = 1'b1;
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end else begin
            fair_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = RUN;
          end
        end
        default: begin
          hold_cnt_d = '0;
          state_d    = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      last_a_q   <= '0;
      last_b_q   <= '0;
      hold_cnt_q <= '0;
      aligned_q  <= 1'b0;
      mismatch_q <= 1'b0;
      fair_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_a_q   <= last_a_d;
      last_b_q   <= last_b_d;
      hold_cnt_q <= hold_cnt_d;
      aligned_q  <= aligned_d;
      mismatch_q <= mismatch_d;
      fair_q     <= fair_d;
    end
  end

  // Both codeblocks stay frozen while the scheduler itself is in reset
  assign stutter_a      = !rst_n || stall_a;
  assign stutter_b      = !rst_n || stall_b;
  assign aligned        = aligned_q;
  assign mismatch       = mismatch_q;
  assign fair_violation = fair_q;

`ifdef STUTTER_TRACE_EN
  logic [7:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (enable && stall_a && (cnt_a_q != 8'hFF)) cnt_a_d = cnt_a_q + 8'd1;
    if (enable && stall_b && (cnt_b_q != 8'hFF)) cnt_b_d = cnt_b_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign stutter_cnt_a = cnt_a_q;
  assign stutter_cnt_b = cnt_b_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stutter_scheduler.sv
`default_nettype none
// ============================================================================
// tb_stutter_scheduler : directed scenarios plus randomized traffic checked
//   against a behavioural pairing model. Rev 1.0
// ============================================================================
module tb_stutter_scheduler;

  localparam int W           = 2;
  localparam int MAX_STUTTER = 7;
  localparam int CNT_W       = 8;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] obs_a  = '0;
  logic [W-1:0] obs_b  = '0;
  logic         stutter_a, stutter_b, aligned, mismatch, fair_violation;
`ifdef STUTTER_TRACE_EN
  logic [7:0]   stutter_cnt_a, stutter_cnt_b;
`endif

  always #5 clk = ~clk;

  stutter_scheduler #(
    .W(W), .MAX_STUTTER(MAX_STUTTER), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .obs_a(obs_a),
    .obs_b(obs_b),
    .stutter_a(stutter_a),
    .stutter_b(stutter_b),
    .aligned(aligned),
    .mismatch(mismatch),
    .fair_violation(fair_violation)
`ifdef STUTTER_TRACE_EN
    ,
    .stutter_cnt_a(stutter_cnt_a),
    .stutter_cnt_b(stutter_cnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Pairing model: which side leads with an unpaired change, and for how
  // many cycles that leader has been held so far.
  logic [W-1:0] m_last_a, m_last_b;
  int           m_lead;
  int           m_frozen;
  int           m_cnt_a, m_cnt_b;
  bit           m_aligned, m_mismatch, m_fair;
  bit           e_sa, e_sb;
  bit           s_sa, s_sb, s_al, s_mm, s_fv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last_a = '0; m_last_b = '0;
    m_lead = 0; m_frozen = 0;
    m_cnt_a = 0; m_cnt_b = 0;
    m_aligned = 0; m_mismatch = 0; m_fair = 0;
  endtask

  task automatic model_outputs();
    bit ca, cb;
    ca = (obs_a != m_last_a);
    cb = (obs_b != m_last_b);
    e_sa = 0; e_sb = 0;
    if (!rst_n || !enable) begin
      e_sa = 1; e_sb = 1;
    end else if (m_lead == 0) begin
      e_sa = ca && !cb;
      e_sb = cb && !ca;
    end else if (m_lead == 1) begin
      e_sa = !cb && (m_frozen < MAX_STUTTER);
    end else begin
      e_sb = !ca && (m_frozen < MAX_STUTTER);
    end
  endtask

  task automatic model_advance();
    bit ca, cb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!enable) begin
      m_aligned = 0;
      return;
    end
    model_outputs();
    if (e_sa && m_cnt_a < 255) m_cnt_a++;
    if (e_sb && m_cnt_b < 255) m_cnt_b++;
    ca = (obs_a != m_last_a);
    cb = (obs_b != m_last_b);
    m_aligned = 0;
    if (m_lead == 0) begin
      if (ca && cb) begin
        m_last_a = obs_a; m_last_b = obs_b; m_aligned = 1;
        if (obs_a != obs_b) m_mismatch = 1;
      end else if (ca) begin
        m_last_a = obs_a; m_lead = 1; m_frozen = 1;
      end else if (cb) begin
        m_last_b = obs_b; m_lead = 2; m_frozen = 1;
      end
    end else if (m_lead == 1) begin
      if (cb) begin
        m_last_b = obs_b; m_lead = 0; m_aligned = 1;
        if (obs_b != m_last_a) m_mismatch = 1;
      end else if (m_frozen < MAX_STUTTER) m_frozen++;
      else begin m_fair = 1; m_lead = 0; end
    end else begin
      if (ca) begin
        m_last_a = obs_a; m_lead = 0; m_aligned = 1;
        if (obs_a != m_last_b) m_mismatch = 1;
      end else if (m_frozen < MAX_STUTTER) m_frozen++;
      else begin m_fair = 1; m_lead = 0; end
    end
  endtask

  // One cycle: drive after the falling edge, compare, then follow the edge
  task automatic step(input logic ra, input logic en, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst_n = ra; enable = en; obs_a = a; obs_b = b;
    #2;
    if (!rst_n) model_reset();
    model_outputs();
    s_sa = stutter_a; s_sb = stutter_b; s_al = aligned; s_mm = mismatch; s_fv = fair_violation;
    check("stutter_a", {31'd0, stutter_a}, {31'd0, e_sa});
    check("stutter_b", {31'd0, stutter_b}, {31'd0, e_sb});
    check("aligned", {31'd0, aligned}, {31'd0, m_aligned});
    check("mismatch", {31'd0, mismatch}, {31'd0, m_mismatch});
    check("fair_violation", {31'd0, fair_violation}, {31'd0, m_fair});
`ifdef STUTTER_TRACE_EN
    check("stutter_cnt_a", {24'd0, stutter_cnt_a}, 32'(m_cnt_a));
    check("stutter_cnt_b", {24'd0, stutter_cnt_b}, 32'(m_cnt_b));
`endif
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b1, '0, '0);
  endtask

  initial begin
    int n;
    logic         ra, en;
    logic [W-1:0] a, b;
    model_reset();

    // Reset then idle
    step(1'b0, 1'b1, 2'd0, 2'd0);
    check("reset_stutter_a", {31'd0, s_sa}, 32'd1);
    check("reset_stutter_b", {31'd0, s_sb}, 32'd1);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    repeat (10) step(1'b1, 1'b1, 2'd0, 2'd0);
    check("idle_stutter_a", {31'd0, s_sa}, 32'd0);
    check("idle_stutter_b", {31'd0, s_sb}, 32'd0);
    check("idle_flags", {29'd0, s_al, s_mm, s_fv}, 32'd0);

    // Simultaneous change
    step(1'b1, 1'b1, 2'd1, 2'd1);
    check("sim_no_stutter", {30'd0, s_sa, s_sb}, 32'd0);
    step(1'b1, 1'b1, 2'd1, 2'd1);
    check("sim_aligned", {31'd0, s_al}, 32'd1);
    check("sim_mismatch", {31'd0, s_mm}, 32'd0);
    step(1'b1, 1'b1, 2'd1, 2'd1);
    check("sim_aligned_pulse", {31'd0, s_al}, 32'd0);

    // A leads B by three cycles
    do_reset();
    n = 0;
    repeat (3) begin
      step(1'b1, 1'b1, 2'd1, 2'd0);
      n += int'(s_sa);
      check("lead_stutter_b", {31'd0, s_sb}, 32'd0);
    end
    check("lead_stutter_a_cycles", 32'(n), 32'd3);
    step(1'b1, 1'b1, 2'd1, 2'd1);
    check("lead_release", {30'd0, s_sa, s_sb}, 32'd0);
    step(1'b1, 1'b1, 2'd1, 2'd1);
    check("lead_aligned", {31'd0, s_al}, 32'd1);

    // Differing values paired up
    do_reset();
    step(1'b1, 1'b1, 2'd0, 2'd2);
    check("mm_hold_b0", {31'd0, s_sb}, 32'd1);
    step(1'b1, 1'b1, 2'd0, 2'd2);
    check("mm_hold_b1", {31'd0, s_sb}, 32'd1);
    step(1'b1, 1'b1, 2'd3, 2'd2);
    check("mm_release", {30'd0, s_sa, s_sb}, 32'd0);
    check("mm_not_yet", {31'd0, s_mm}, 32'd0);
    step(1'b1, 1'b1, 2'd3, 2'd2);
    check("mm_set", {31'd0, s_mm}, 32'd1);
    repeat (3) step(1'b1, 1'b1, 2'd3, 2'd2);
    check("mm_sticky", {31'd0, s_mm}, 32'd1);

    // Fairness bound
    do_reset();
    n = 0;
    repeat (9) begin
      step(1'b1, 1'b1, 2'd1, 2'd0);
      n += int'(s_sa);
    end
    check("fair_stutter_cycles", 32'(n), 32'(MAX_STUTTER));
    check("fair_flag", {31'd0, s_fv}, 32'd1);
    check("fair_back_to_run", {31'd0, s_sa}, 32'd0);

    // enable low in the middle of a hold
    do_reset();
    step(1'b1, 1'b1, 2'd1, 2'd0);
    step(1'b1, 1'b1, 2'd1, 2'd0);
    repeat (4) begin
      step(1'b1, 1'b0, 2'd1, 2'd0);
      check("en_low_stutter", {30'd0, s_sa, s_sb}, 32'd3);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 2'd1, 2'd0);
      if (!s_sa) break;
      n++;
    end
    check("en_resume_hold_cycles", 32'(n), 32'd5);
    check("en_fair_after_release", {31'd0, s_fv}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      ra = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 19) != 0);
      a  = obs_a;
      b  = obs_b;
      if ($urandom_range(0, 3) == 0) a = W'($urandom);
      if ($urandom_range(0, 3) == 0) b = W'($urandom);
      step(ra, en, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
